// File: rtl/sorter_pkg.sv
// sorter_pkg: shared state encoding, default sizes and index-width helper for the bubble sorter
package sorter_pkg;
  typedef enum logic [1:0] {LOAD, SORT, OUT} state_e;
  localparam int N_DEF = 4;
  localparam int W_DEF = 8;
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/sort_reg_bank.sv
// sort_reg_bank: N x W storage with an indexed load port and an adjacent-pair swap port
module sort_reg_bank import sorter_pkg::*; #(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we_i,
  input  logic [idx_w(N)-1:0]    widx_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   swap_i,
  input  logic [idx_w(N)-1:0]    sidx_i,
  output logic [N*W-1:0]         data_o
);
  logic [W-1:0] mem_q [N];
  logic [W-1:0] mem_d [N];
  always_comb begin
    mem_d = mem_q;
    if (swap_i) begin
      mem_d[sidx_i]        = mem_q[sidx_i + 1'b1];
      mem_d[sidx_i + 1'b1] = mem_q[sidx_i];
    end
    if (we_i) mem_d[widx_i] = wdata_i;
  end
  always_ff @(posedge clk)
    if (reset) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  always_comb
    for (int k = 0; k < N; k++) data_o[k*W +: W] = mem_q[k];
endmodule

// File: rtl/sort_controller.sv
// sort_controller: load/sort/output sequencer for an in-place bubble sorter
// SORT_DESCEND_EN selects descending order (largest first); default is ascending.
module sort_controller import sorter_pkg::*; #(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         sorting,
  output logic         done
);
  localparam int IW = idx_w(N);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, pass_q, pass_d, idx1;
  logic swp_q, swp_d, done_q, done_d, we, sw, hit;
  logic [W-1:0] od_q, od_d, a, b, e0;
  logic [N*W-1:0] ent;
  sort_reg_bank #(.N(N), .W(W)) u_bank (
    .clk(clk), .reset(reset),
    .we_i(we), .widx_i(idx_q), .wdata_i(in_data),
    .swap_i(sw), .sidx_i(idx_q),
    .data_o(ent)
  );
  assign idx1 = idx_q + 1'b1;
  assign a    = ent[W*int'(idx_q) +: W];
  assign b    = ent[W*int'(idx1) +: W];
  assign e0   = ent[W-1:0];
`ifdef SORT_DESCEND_EN
  assign hit = a < b;
`else
  assign hit = a > b;
`endif
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    swp_d   = swp_q;
    od_d    = od_q;
    done_d  = 1'b0;
    we      = 1'b0;
    sw      = 1'b0;
    unique case (state_q)
      LOAD: if (in_valid) begin
        we    = 1'b1;
        idx_d = (idx_q == IW'(N-1)) ? '0 : idx1;
        if (idx_q == IW'(N-1)) begin
          state_d = SORT;
          pass_d  = '0;
          swp_d   = 1'b0;
        end
      end
      SORT: begin
        sw    = hit;
        swp_d = swp_q | hit;
        idx_d = idx1;
        if (idx_q == IW'(N-2)) begin
          idx_d = '0;
          // the swap made in this cycle counts toward early exit; for N=2 it also rewrites entry 0
          if (!(swp_q || hit) || pass_q == IW'(N-2)) begin
            state_d = OUT;
            od_d    = (hit && idx_q == '0) ? b : e0;
          end else begin
            pass_d = pass_q + 1'b1;
            swp_d  = 1'b0;
          end
        end
      end
      OUT: if (out_ready) begin
        idx_d = (idx_q == IW'(N-1)) ? '0 : idx1;
        od_d  = (idx_q == IW'(N-1)) ? '0 : b;
        if (idx_q == IW'(N-1)) begin
          state_d = LOAD;
          done_d  = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= LOAD;
      idx_q   <= '0;
      pass_q  <= '0;
      swp_q   <= 1'b0;
      od_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      swp_q   <= swp_d;
      od_q    <= od_d;
      done_q  <= done_d;
    end
  assign in_ready  = state_q == LOAD;
  assign out_valid = state_q == OUT;
  assign sorting   = state_q == SORT;
  assign out_data  = od_q;
  assign done      = done_q;
endmodule
